// File: rtl/ysyx_bus_pkg.sv
// Shared types and constants for the core-side AXI bus: FSM/owner enums,
// the byte-mask to AXI size encoder and the SoC address map.
package ysyx_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW_W = 3'd3,
    ST_B    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OWN_IFU   = 2'd0,
    OWN_LOAD  = 2'd1,
    OWN_STORE = 2'd2
  } owner_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [2:0] SIZE_WORD = 3'd2;

  localparam logic [31:0] SRAM_BASE  = 32'h0f00_0000;
  localparam logic [31:0] MROM_BASE  = 32'h2000_0000;
  localparam logic [31:0] FLASH_BASE = 32'h3000_0000;
  localparam logic [31:0] PSRAM_BASE = 32'h8000_0000;
  localparam logic [31:0] SDRAM_BASE = 32'ha000_0000;

  // Unsupported masks fall back to a single byte.
  function automatic logic [2:0] size_enc(input logic [7:0] mask);
    case (mask)
      8'h01:   return 3'd0;
      8'h03:   return 3'd1;
      8'h0f:   return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_axi_lane_align.sv
// Combinational lane steering between 32-bit requester data and the 64-bit
// AXI data bus: read extract/right-align, write replicate and strobe shift.
module ysyx_axi_lane_align (
  input  logic [2:0]  addr_lo,
  input  logic [63:0] bus_rdata,
  output logic [31:0] rd_data,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_mask,
  output logic [63:0] bus_wdata,
  output logic [7:0]  bus_wstrb
);

  logic [4:0]  byte_sh;
  logic [31:0] rd_lane;
  logic [31:0] wr_shift;
  logic [3:0]  strb_shift;

  always_comb begin
    byte_sh    = {addr_lo[1:0], 3'b000};
    rd_lane    = addr_lo[2] ? bus_rdata[63:32] : bus_rdata[31:0];
    rd_data    = rd_lane >> byte_sh;
    wr_shift   = wr_data << byte_sh;
    // Data goes on both halves; the strobe alone selects the live half.
    bus_wdata  = {wr_shift, wr_shift};
    strb_shift = wr_mask << addr_lo[1:0];
    bus_wstrb  = addr_lo[2] ? {strb_shift, 4'b0000} : {4'b0000, strb_shift};
  end

endmodule

// File: rtl/ysyx_axi_txn_sched.sv
// Single-outstanding AXI4 master sequencer for IFU fetch, LSU load and LSU
// store, with response routing, sticky bus error and an IFU starvation guard.
module ysyx_axi_txn_sched
  import ysyx_bus_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic              ifu_arvalid,
  output logic [DATA_W-1:0] ifu_rdata_o,
  output logic              ifu_rvalid_o,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic              lsu_arvalid,
  input  logic [7:0]        lsu_rstrb,
  output logic [DATA_W-1:0] lsu_rdata_o,
  output logic              lsu_rvalid_o,
  input  logic [ADDR_W-1:0] lsu_awaddr,
  input  logic              lsu_wvalid,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [7:0]        lsu_wstrb,
  output logic              lsu_wready_o,
  output logic              io_master_arvalid,
  input  logic              io_master_arready,
  output logic [ADDR_W-1:0] io_master_araddr,
  output logic [2:0]        io_master_arsize,
  input  logic              io_master_rvalid,
  output logic              io_master_rready,
  input  logic [63:0]       io_master_rdata,
  input  logic [1:0]        io_master_rresp,
  output logic              io_master_awvalid,
  input  logic              io_master_awready,
  output logic [ADDR_W-1:0] io_master_awaddr,
  output logic [2:0]        io_master_awsize,
  output logic              io_master_wvalid,
  input  logic              io_master_wready,
  output logic [63:0]       io_master_wdata,
  output logic [7:0]        io_master_wstrb,
  output logic              io_master_wlast,
  input  logic              io_master_bvalid,
  output logic              io_master_bready,
  input  logic [1:0]        io_master_bresp,
  output logic              bus_err_o,
  output logic [2:0]        dbg_state_o
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_CAP = SW'(STARVE_MAX);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          size_q, size_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          wmask_q, wmask_d;
  logic [SW-1:0]       starve_q, starve_d;
  logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ifu_rvalid_q, ifu_rvalid_d;
  logic                lsu_rvalid_q, lsu_rvalid_d;
  logic                lsu_wready_q, lsu_wready_d;
  logic                bus_err_q, bus_err_d;
  logic                pulse_busy, aw_fin, w_fin;
  logic [31:0]         rd_lane;

  ysyx_axi_lane_align u_align (
    .addr_lo   (addr_q[2:0]),
    .bus_rdata (io_master_rdata),
    .rd_data   (rd_lane),
    .wr_data   (wdata_q),
    .wr_mask   (wmask_q),
    .bus_wdata (io_master_wdata),
    .bus_wstrb (io_master_wstrb)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    starve_d     = starve_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    rdata_d      = rdata_q;
    ifu_rvalid_d = 1'b0;
    lsu_rvalid_d = 1'b0;
    lsu_wready_d = 1'b0;
    bus_err_d    = bus_err_q;
    // A completion pulse means the requester has not yet dropped its valid.
    pulse_busy   = ifu_rvalid_q | lsu_rvalid_q | lsu_wready_q;
    aw_fin       = aw_done_q | io_master_awready;
    w_fin        = w_done_q | io_master_wready;
    unique case (state_q)
      ST_IDLE: if (!pulse_busy) begin
        if (ifu_arvalid && (starve_q == STARVE_CAP || !(lsu_wvalid || lsu_arvalid))) begin
          state_d  = ST_AR;
          owner_d  = OWN_IFU;
          addr_d   = ifu_araddr;
          size_d   = SIZE_WORD;
          starve_d = '0;
        end else if (lsu_wvalid) begin
          state_d = ST_AW_W;
          owner_d = OWN_STORE;
          addr_d  = lsu_awaddr;
          size_d  = size_enc(lsu_wstrb);
          wdata_d = lsu_wdata;
          wmask_d = lsu_wstrb[3:0];
          if (ifu_arvalid && starve_q != STARVE_CAP) starve_d = starve_q + 1'b1;
        end else if (lsu_arvalid) begin
          state_d = ST_AR;
          owner_d = OWN_LOAD;
          addr_d  = lsu_araddr;
          size_d  = size_enc(lsu_rstrb);
          if (ifu_arvalid && starve_q != STARVE_CAP) starve_d = starve_q + 1'b1;
        end
      end
      ST_AR: if (io_master_arready) state_d = ST_R;
      ST_R: if (io_master_rvalid) begin
        rdata_d      = rd_lane;
        ifu_rvalid_d = (owner_q == OWN_IFU);
        lsu_rvalid_d = (owner_q == OWN_LOAD);
        if (io_master_rresp != RESP_OKAY) bus_err_d = 1'b1;
        state_d      = ST_IDLE;
      end
      ST_AW_W: begin
        if (aw_fin && w_fin) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = ST_B;
        end else begin
          aw_done_d = aw_fin;
          w_done_d  = w_fin;
        end
      end
      ST_B: if (io_master_bvalid) begin
        lsu_wready_d = 1'b1;
        if (io_master_bresp != RESP_OKAY) bus_err_d = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_IFU;
      addr_q       <= '0;
      size_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      starve_q     <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      rdata_q      <= '0;
      ifu_rvalid_q <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      lsu_wready_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      starve_q     <= starve_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      rdata_q      <= rdata_d;
      ifu_rvalid_q <= ifu_rvalid_d;
      lsu_rvalid_q <= lsu_rvalid_d;
      lsu_wready_q <= lsu_wready_d;
      bus_err_q    <= bus_err_d;
    end
  end

  // valid/ready: each AXI valid is raised from latched state and held until
  // the cycle its ready is sampled high; requester valids are held until the
  // one-cycle completion pulse and dropped on the following cycle.
  assign io_master_arvalid = (state_q == ST_AR);
  assign io_master_rready  = (state_q == ST_R);
  assign io_master_awvalid = (state_q == ST_AW_W) && !aw_done_q;
  assign io_master_wvalid  = (state_q == ST_AW_W) && !w_done_q;
  assign io_master_wlast   = io_master_wvalid;
  assign io_master_bready  = (state_q == ST_B);
  assign io_master_araddr  = addr_q;
  assign io_master_awaddr  = addr_q;
  assign io_master_arsize  = size_q;
  assign io_master_awsize  = size_q;
  assign ifu_rdata_o       = rdata_q;
  assign lsu_rdata_o       = rdata_q;
  assign ifu_rvalid_o      = ifu_rvalid_q;
  assign lsu_rvalid_o      = lsu_rvalid_q;
  assign lsu_wready_o      = lsu_wready_q;
  assign bus_err_o         = bus_err_q;
  assign dbg_state_o       = state_q;

endmodule
